sat_updown_counter: RTL and testbench

Parametrised signed up/down counter, the successor to the fixed 8-bit counter. It adds configurable width and bounds, three overflow modes (hold, saturate, wrap) and a sticky overflow flag with clear. Boundary flags and an event pulse are also provided. It sits in the signed-operations group as the general accumulator/step counter for datapath and control blocks.

---
 rtl/signed_ops_pkg.sv | 9 +
 rtl/range_resolve.sv | 33 +++
 rtl/sat_updown_counter.sv | 47 ++++
 tb/tb_sat_updown_counter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/signed_ops_pkg.sv
// signed_ops_pkg: mode encodings and sign-extension helper shared by signed counters
package signed_ops_pkg;
  localparam int MODE_HOLD = 0;
  localparam int MODE_SAT  = 1;
  localparam int MODE_WRAP = 2;
  function automatic logic signed [31:0] sext(input logic [31:0] v, input int w);
    return signed'(v << (32 - w)) >>> (32 - w);
  endfunction
endpackage

// File: rtl/range_resolve.sv
// range_resolve: maps a widened candidate value onto the legal range according to the overflow policy
module range_resolve import signed_ops_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int HI    = 2**(WIDTH-1)-1,
  parameter int LO    = -(2**(WIDTH-1)-1),
  parameter int MODE  = MODE_HOLD
) (
  input  logic signed [WIDTH+1:0] t,
  input  logic signed [WIDTH+1:0] qx,
  input  logic signed [WIDTH+1:0] b,
  input  logic                    is_load,
  output logic signed [WIDTH-1:0] nq,
  output logic                    oor
);
  localparam logic signed [WIDTH+1:0] H = (WIDTH+2)'(HI);
  localparam logic signed [WIDTH+1:0] L = (WIDTH+2)'(LO);
  localparam logic signed [WIDTH+1:0] S = (WIDTH+2)'(HI - LO + 1);
  logic signed [WIDTH+1:0] clamp, wrapped, bm, r;
  logic above, below, big;
  assign above   = t > H;
  assign below   = t < L;
  assign oor     = above | below;
  assign clamp   = above ? H : L;
  assign wrapped = above ? t - S : t + S;
  assign bm      = b < 0 ? -b : b;
  assign big     = bm > H - L;
  // A step too large to wrap once is treated as HOLD; failed loads fall back to zero outside SAT
  always_comb r = !oor ? t :
                  MODE == MODE_SAT ? clamp :
                  is_load ? '0 :
                  (MODE == MODE_WRAP && !big) ? wrapped : qx;
  assign nq = WIDTH'(r);
endmodule

// File: rtl/sat_updown_counter.sv
// sat_updown_counter: signed up/down counter with bounded range, overflow policy and sticky overflow
module sat_updown_counter import signed_ops_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int HI    = 2**(WIDTH-1)-1,
  parameter int LO    = -(2**(WIDTH-1)-1),
  parameter int MODE  = MODE_HOLD
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ld,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    up,
  input  logic                    dn,
  input  logic                    clr_ovf,
  output logic signed [WIDTH-1:0] q,
  output logic                    at_hi,
  output logic                    at_lo,
  output logic                    ovf,
  output logic                    evt
);
  logic signed [WIDTH+1:0] qx, ax, bx, t;
  logic signed [WIDTH-1:0] nq;
  logic act, oor;
  assign qx = (WIDTH+2)'(sext(32'(unsigned'(q)), WIDTH));
  assign ax = (WIDTH+2)'(sext(32'(unsigned'(a)), WIDTH));
  assign bx = (WIDTH+2)'(sext(32'(unsigned'(b)), WIDTH));
  assign act = ld | up | dn;
  // Priority mux: load beats up beats down; widened so the range check never sees a native wrap
  always_comb t = ld ? ax : up ? qx + bx : qx - bx;
  range_resolve #(.WIDTH(WIDTH), .HI(HI), .LO(LO), .MODE(MODE)) u_res (
    .t(t), .qx(qx), .b(bx), .is_load(ld), .nq(nq), .oor(oor)
  );
  assign at_hi = q == (WIDTH)'(HI);
  assign at_lo = q == (WIDTH)'(LO);
  // Count register, event pulse and sticky flag where a new overflow outranks a clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q   <= '0;
      ovf <= 1'b0;
      evt <= 1'b0;
    end else begin
      if (act) q <= nq;
      evt <= act & oor;
      ovf <= (act & oor) | (ovf & ~clr_ovf);
    end
endmodule

// File: tb/tb_sat_updown_counter.sv
// tb_sat_updown_counter: six counter configurations on shared stimulus against an integer model
module tb_sat_updown_counter;
  logic clk = 0, rst_n = 0, ld = 0, up = 0, dn = 0, clr_ovf = 0;
  logic signed [7:0] a8 = 0, b8 = 0;
  logic signed [3:0] a4 = 0, b4 = 0;
  logic signed [7:0] q8 [3];
  logic signed [3:0] q4 [3];
  logic h8 [3], l8 [3], o8 [3], e8 [3], h4 [3], l4 [3], o4 [3], e4 [3];
  int vectors = 0, miscompares = 0;
  int MH [6] = '{127, 127, 9, 7, 7, 7};
  int ML [6] = '{-127, -127, 0, -7, -7, -7};
  int MM [6] = '{0, 1, 2, 0, 1, 2};
  int mq [6] = '{0, 0, 0, 0, 0, 0};
  bit movf [6] = '{0, 0, 0, 0, 0, 0};
  bit mevt [6] = '{0, 0, 0, 0, 0, 0};
  always #5 clk = ~clk;
  for (genvar m = 0; m < 3; m++) begin : g8
    sat_updown_counter #(.WIDTH(8), .HI(m == 2 ? 9 : 127), .LO(m == 2 ? 0 : -127), .MODE(m)) u (
      .clk(clk), .rst_n(rst_n), .ld(ld), .a(a8), .b(b8), .up(up), .dn(dn), .clr_ovf(clr_ovf),
      .q(q8[m]), .at_hi(h8[m]), .at_lo(l8[m]), .ovf(o8[m]), .evt(e8[m]));
  end
  for (genvar m = 0; m < 3; m++) begin : g4
    sat_updown_counter #(.WIDTH(4), .MODE(m)) u (
      .clk(clk), .rst_n(rst_n), .ld(ld), .a(a4), .b(b4), .up(up), .dn(dn), .clr_ovf(clr_ovf),
      .q(q4[m]), .at_hi(h4[m]), .at_lo(l4[m]), .ovf(o4[m]), .evt(e4[m]));
  end
  function automatic int dq(int i);
    return i < 3 ? int'(q8[i]) : int'(q4[i-3]);
  endfunction
  function automatic int df(int i, int k);
    logic v [4];
    v = i < 3 ? '{h8[i], l8[i], o8[i], e8[i]} : '{h4[i-3], l4[i-3], o4[i-3], e4[i-3]};
    return int'(v[k]);
  endfunction
  task automatic chk(input string n, input int i, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s inst%0d at %0t: got %0d expected %0d", n, i, $time, act, exp);
    end
  endtask
  // Behavioural rule set: plain integer arithmetic over the documented overflow policies
  function automatic void model(input int hi, lo, mode, q, input bit l, u, d, input int av, bv,
                                output int nq, output bit o);
    int t;
    o = 0;
    nq = q;
    if (l) begin
      if (av >= lo && av <= hi) nq = av;
      else begin
        o = 1;
        nq = mode == 1 ? (av > hi ? hi : lo) : 0;
      end
    end else if (u || d) begin
      t = u ? q + bv : q - bv;
      if (t >= lo && t <= hi) nq = t;
      else begin
        o = 1;
        if (mode == 1) nq = t > hi ? hi : lo;
        else if (mode == 2 && (bv < 0 ? -bv : bv) <= hi - lo) nq = t > hi ? t - (hi - lo + 1) : t + (hi - lo + 1);
      end
    end
  endfunction
  task automatic step(input bit l, u, d, c, input int av, bv);
    ld = l; up = u; dn = d; clr_ovf = c;
    a8 = 8'(av); b8 = 8'(bv);
    a4 = 4'($urandom); b4 = 4'($urandom);
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      int nq, ai, bi;
      bit o;
      ai = i < 3 ? int'(a8) : int'(a4);
      bi = i < 3 ? int'(b8) : int'(b4);
      model(MH[i], ML[i], MM[i], mq[i], l, u, d, ai, bi, nq, o);
      mq[i] = nq;
      mevt[i] = o;
      movf[i] = o | (movf[i] & ~c);
    end
    #1;
  endtask
  // Every negedge: all outputs of all instances against the model
  always @(negedge clk)
    for (int i = 0; i < 6; i++) begin
      chk("q", i, dq(i), mq[i]);
      chk("at_hi", i, df(i, 0), int'(mq[i] == MH[i]));
      chk("at_lo", i, df(i, 1), int'(mq[i] == ML[i]));
      chk("ovf", i, df(i, 2), int'(movf[i]));
      chk("evt", i, df(i, 3), int'(mevt[i]));
    end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", 0, int'(q8[0]), 0);
    rst_n = 1;
    step(1, 0, 0, 0, -128, 0);
    chk("ldbad_ovf", 0, int'(o8[0]), 1);
    step(1, 0, 0, 0, 55, 0);
    chk("ld55_q", 0, int'(q8[0]), 55);
    #3;
    rst_n = 0;
    for (int i = 0; i < 6; i++) begin mq[i] = 0; movf[i] = 0; mevt[i] = 0; end
    #1;
    chk("async_q", 0, int'(q8[0]), 0);
    chk("async_ovf", 0, int'(o8[0]), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    step(1, 0, 0, 0, -20, 0);
    chk("rel_ld_q", 0, int'(q8[0]), -20);
    step(1, 0, 0, 0, 120, 0);
    step(0, 1, 0, 0, 0, 10);
    chk("hold_q", 0, int'(q8[0]), 120);
    chk("hold_evt", 0, int'(e8[0]), 1);
    chk("hold_ovf", 0, int'(o8[0]), 1);
    step(0, 0, 0, 1, 0, 0);
    chk("clr_ovf", 0, int'(o8[0]), 0);
    chk("idle_evt", 0, int'(e8[0]), 0);
    step(0, 0, 1, 0, 0, -7);
    chk("hold_dn_q", 0, int'(q8[0]), 127);
    chk("hold_at_hi", 0, int'(h8[0]), 1);
    step(1, 0, 0, 0, -120, 0);
    step(0, 0, 1, 0, 0, 20);
    chk("sat_q", 1, int'(q8[1]), -127);
    chk("sat_at_lo", 1, int'(l8[1]), 1);
    chk("sat_ovf", 1, int'(o8[1]), 1);
    step(1, 0, 0, 0, -128, 0);
    chk("sat_ld_q", 1, int'(q8[1]), -127);
    chk("sat_ld_evt", 1, int'(e8[1]), 1);
    step(1, 0, 0, 1, 8, 0);
    step(0, 1, 0, 0, 0, 5);
    chk("wrap_up_q", 2, int'(q8[2]), 3);
    chk("wrap_ovf", 2, int'(o8[2]), 1);
    step(0, 0, 1, 0, 0, 4);
    chk("wrap_dn_q", 2, int'(q8[2]), 9);
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 12);
    chk("wrap_big_q", 2, int'(q8[2]), 9);
    chk("wrap_big_ovf", 2, int'(o8[2]), 1);
    step(1, 1, 1, 0, 5, 2);
    chk("prio_ld_q", 0, int'(q8[0]), 5);
    step(0, 1, 1, 0, 0, 2);
    chk("prio_up_q", 0, int'(q8[0]), 7);
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("b0_q", 0, int'(q8[0]), 7);
    chk("b0_evt", 0, int'(e8[0]), 0);
    step(0, 1, 0, 1, 0, 127);
    chk("set_wins_ovf", 0, int'(o8[0]), 1);
    for (int n = 0; n < 10000; n++) begin
      int bv;
      bv = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 16)) - 8;
      step($urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0,
           int'($urandom_range(0, 255)) - 128, bv);
    end
    ld = 0; up = 0; dn = 0; clr_ovf = 0;
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
